// File: rtl/core_md_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: op codes,
// FSM state encoding and the most-negative-value helper.
package core_md_pkg;

  // md_op codes follow the RV32M/RV64M funct3 encoding
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // FSM state encoding
  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_MUL  = 2'd1;
  localparam md_state_t ST_DIV  = 2'd2;
  localparam md_state_t ST_FIX  = 2'd3;

  // Most-negative two's complement value for a given width (width <= 64)
  function automatic logic [63:0] md_most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/core_md_divider.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per cycle,
// DATA_WIDTH iterations after the load edge.
module core_md_divider
  import core_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;
  logic          diff_unused;

  // Partial remainder shifted left with the next dividend bit, then trial subtract
  assign shifted     = {rem, quo[W-1]};
  assign diff        = {1'b0, shifted} - {2'b00, dvs};
  // A non-negative trial result is always below the divisor, so bit W is never needed
  assign diff_unused = diff[W];

  assign ready_o     = ~busy;
  assign done_o      = busy & (cnt == CW'(1));
  assign quotient_o  = quo;
  assign remainder_o = rem;

  // Iteration control: load on start, count down DATA_WIDTH steps, abort on kill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (kill_i) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start_i && !busy) begin
      busy <= 1'b1;
      cnt  <= CW'(W);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  // Datapath: restoring step, quotient bits shift in from the LSB
  always_ff @(posedge clk) begin
    if (start_i && !busy) begin
      quo <= dividend_i;
      rem <= '0;
      dvs <= divisor_i;
    end else if (busy) begin
      if (!diff[W+1]) begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/core_execution_unit_md.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with start/ready handshake,
// single-cycle valid pulse, registered result and kill for pipeline flush.
module core_execution_unit_md
  import core_md_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2,
  parameter int MD_OP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [MD_OP_WIDTH-1:0] md_op_i,
  input  logic [DATA_WIDTH-1:0]  rs1_i,
  input  logic [DATA_WIDTH-1:0]  rs2_i,
  input  logic                   kill_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  result_o
);

  localparam int              W        = DATA_WIDTH;
  localparam int              CW       = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [W-1:0]    MOST_NEG = W'(md_most_neg(W));
  localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_LATENCY - 2);

  function automatic logic is_div_op(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_sdiv(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_rem(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // Magnitude on a W+1-bit signed internal so the most-negative value survives
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] x, input logic sgn);
    logic signed [W:0] ext;
    ext = sgn ? $signed({x[W-1], x}) : $signed({1'b0, x});
    if (ext < 0) ext = -ext;
    return ext[W-1:0];
  endfunction

  // Re-apply a sign to an unsigned magnitude on a W+1-bit internal
  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] x, input logic neg);
    logic signed [W:0] t;
    t = $signed({1'b0, x});
    if (neg) t = -t;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mul_sel(input logic signed [2*W-1:0] p,
                                           input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  md_state_t               state;
  logic [CW-1:0]           mul_cnt;
  logic [MD_OP_WIDTH-1:0]  op_q;
  logic                    neg_q;
  logic                    neg_r;

  logic                    accept;
  logic                    sdiv;
  logic                    div_zero;
  logic                    div_ovf;
  logic [W-1:0]            fast_res;

  logic                    mul_a_sgn;
  logic                    mul_b_sgn;
  logic signed [2*W-1:0]   mul_a;
  logic signed [2*W-1:0]   mul_b;
  logic signed [2*W-1:0]   prod_p0;
  logic signed [2*W-1:0]   prod_final;

  logic                    div_start;
  logic                    div_ready;
  logic                    div_done;
  logic [W-1:0]            div_quo;
  logic [W-1:0]            div_rem;

  assign ready_o  = (state == ST_IDLE);
  assign accept   = ready_o & start_i & ~kill_i;
  assign sdiv     = is_sdiv(md_op_i);
  assign div_zero = (rs2_i == '0);
  assign div_ovf  = sdiv && (rs1_i == MOST_NEG) && (rs2_i == '1);
  assign fast_res = div_zero ? (is_rem(md_op_i) ? rs1_i : '1)
                             : (is_rem(md_op_i) ? '0 : rs1_i);

  // Sign-extend per op to 2W bits; the low 2W bits of the product are exact for all MUL* ops
  assign mul_a_sgn = (md_op_i == MD_MULH) || (md_op_i == MD_MULHSU);
  assign mul_b_sgn = (md_op_i == MD_MULH);
  assign mul_a     = $signed({{W{mul_a_sgn & rs1_i[W-1]}}, rs1_i});
  assign mul_b     = $signed({{W{mul_b_sgn & rs2_i[W-1]}}, rs2_i});
  assign prod_p0   = mul_a * mul_b;

  generate
    if (MUL_LATENCY == 1) begin : g_mul_comb
      assign prod_final = prod_p0;
    end else begin : g_mul_pipe
      logic signed [2*W-1:0] prod_sr [MUL_LATENCY-1];
      // Product delay line: the product captured at the accept edge reaches the last stage on the final edge
      always_ff @(posedge clk) begin
        prod_sr[0] <= prod_p0;
        for (int i = 1; i < MUL_LATENCY - 1; i++) prod_sr[i] <= prod_sr[i-1];
      end
      assign prod_final = prod_sr[MUL_LATENCY-2];
    end
  endgenerate

  assign div_start = accept & is_div_op(md_op_i) & ~div_zero & ~div_ovf & div_ready;

  core_md_divider #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_divider (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .kill_i      (kill_i),
    .dividend_i  (abs_val(rs1_i, sdiv)),
    .divisor_i   (abs_val(rs2_i, sdiv)),
    .ready_o     (div_ready),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Control FSM and result register; kill in any busy state drops the op silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      mul_cnt  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= md_op_i;
            neg_q   <= sdiv & (rs1_i[W-1] ^ rs2_i[W-1]);
            neg_r   <= sdiv & rs1_i[W-1];
            mul_cnt <= '0;
            if (!is_div_op(md_op_i)) begin
              if (MUL_LATENCY == 1) begin
                result_o <= mul_sel(prod_p0, md_op_i);
                valid_o  <= 1'b1;
              end else begin
                state <= ST_MUL;
              end
            end else if (div_zero || div_ovf) begin
              result_o <= fast_res;
              valid_o  <= 1'b1;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (kill_i) begin
            state <= ST_IDLE;
          end else if (mul_cnt == MUL_LAST) begin
            result_o <= mul_sel(prod_final, op_q);
            valid_o  <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            mul_cnt <= mul_cnt + CW'(1);
          end
        end
        ST_DIV: begin
          if (kill_i)        state <= ST_IDLE;
          else if (div_done) state <= ST_FIX;
        end
        ST_FIX: begin
          if (kill_i) begin
            state <= ST_IDLE;
          end else begin
            result_o <= is_rem(op_q) ? apply_sign(div_rem, neg_r)
                                     : apply_sign(div_quo, neg_q);
            valid_o  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_execution_unit_md.sv
// Directed bench for core_execution_unit_md (DATA_WIDTH=32, MUL_LATENCY=2):
// a vector table of ops with hand-computed results and latencies, plus
// sequences for kill, back-to-back issue and asynchronous reset.
module tb_core_execution_unit_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  md_op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  core_execution_unit_md #(
    .DATA_WIDTH  (32),
    .MUL_LATENCY (2),
    .MD_OP_WIDTH (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .md_op_i  (md_op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, then count cycles until valid_o (bounded)
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit no_wait);
    int cyc;
    bit got;
    bit rdy_seen;
    if (!no_wait) @(negedge clk);
    start_i = 1'b1;
    md_op_i = op;
    rs1_i   = a;
    rs2_i   = b;
    cyc = 0;
    got = 1'b0;
    rdy_seen = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      start_i = 1'b0;
      md_op_i = ~op;
      rs1_i   = ~a;
      rs2_i   = ~b;
      cyc++;
      if (valid_o) got = 1'b1;
      else if (ready_o) rdy_seen = 1'b1;
    end
    check({tag, " result"}, result_o, exp);
    check({tag, " latency"}, cyc, lat);
    check({tag, " ready_low"}, rdy_seen, 1'b0);
  endtask

  initial begin
    logic [31:0] last_exp;
    int vcount;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};  // MUL
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};  // MULH
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};  // MULHU
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2};  // MULHSU
    vecs[4]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};  // MULHU
    vecs[5]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};  // MULH
    vecs[6]  = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 2};  // MUL
    vecs[7]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34}; // DIV
    vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34}; // REM
    vecs[9]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34}; // DIVU
    vecs[10] = '{3'd7, 32'd100,       32'd7,         32'd2,         34}; // REMU
    vecs[11] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};  // DIV by 0
    vecs[12] = '{3'd6, 32'd5,         32'd0,         32'd5,         1};  // REM by 0
    vecs[13] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};  // DIV overflow
    vecs[14] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};  // REM overflow
    vecs[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34}; // DIVU no overflow path
    vecs[16] = '{3'd7, 32'd5,         32'd0,         32'd5,         1};  // REMU by 0
    vecs[17] = '{3'd4, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 34}; // DIV most-negative
    vecs[18] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34}; // REM 7 % -2
    vecs[19] = '{3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         34}; // DIV -7 / -2
    vecs[20] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34}; // DIVU
    last_exp = 32'hFFFF_FFFF;

    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0; md_op_i = '0; rs1_i = '0; rs2_i = '0;
    #12;
    check("reset ready", ready_o, 1'b1);
    check("reset valid", valid_o, 1'b0);
    check("reset result", result_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d pulse", i), valid_o, 1'b0);
    end

    // kill at cycle 10 of a DIV, with an ignored start at cycle 5
    @(negedge clk);
    start_i = 1'b1; md_op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
    vcount = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (valid_o) vcount++;
      if (c == 5) begin
        start_i = 1'b1; md_op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      kill_i = (c == 10);
    end
    @(negedge clk);
    kill_i = 1'b0;
    check("kill div ready", ready_o, 1'b1);
    check("kill div valid", valid_o, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("kill div no_valid", vcount, 0);
    check("kill div result_held", result_o, last_exp);

    // kill together with start in IDLE: nothing accepted
    start_i = 1'b1; kill_i = 1'b1; md_op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    check("kill+start ready", ready_o, 1'b1);
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("kill+start no_valid", vcount, 0);

    // kill on the completing cycle of a MUL
    start_i = 1'b1; md_op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill mul ready", ready_o, 1'b1);
    vcount = valid_o ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("kill mul no_valid", vcount, 0);
    check("kill mul result_held", result_o, last_exp);

    // back-to-back: each new start is driven in the previous valid cycle
    run_op("b2b mul", 3'd0, 32'd3, 32'd5, 32'd15, 2, 1'b0);
    run_op("b2b mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b1);
    run_op("b2b div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op("b2b mul2", 3'd0, 32'd6, 32'd7, 32'd42, 2, 1'b1);

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    start_i = 1'b1; md_op_i = 3'd4; rs1_i = 32'hFFFF_FFF9; rs2_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-div ready_low", ready_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async rst ready", ready_o, 1'b1);
    check("async rst valid", valid_o, 1'b0);
    check("async rst result", result_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post-reset rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
